// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: function codes from the ALU control decoder,
// the multiply/divide FSM state type and opcode-class helpers.
package mips_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_SRA   = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV  = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV  = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV  = 6'b000111;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
  localparam logic [5:0] FUNCT_NOP   = 6'b111111;

  typedef enum logic {IDLE, BUSY} md_state_e;

  // Ops that start an iterative multiply/divide.
  function automatic logic is_muldiv_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // Ops that touch HI/LO and so must wait for an in-flight mul/div.
  function automatic logic needs_hilo(input logic [5:0] f);
    return is_muldiv_op(f) ||
           (f == FUNCT_MFHI) || (f == FUNCT_MFLO) ||
           (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
  endfunction

endpackage

// File: rtl/mips_muldiv.sv
// Iterative 32-cycle multiply (shift-add) / divide (restoring) unit.
// Works on magnitudes; signs are fixed up on the final cycle's outputs.
module mips_muldiv
  import mips_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [5:0]      fncode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  md_state_e         state;
  logic [4:0]        count;
  logic              is_div, neg_lo, neg_hi, div_zero;
  logic [XLEN-1:0]   a_raw, opnd;
  logic [2*XLEN-1:0] acc, acc_next;

  logic            start_signed, start_div;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   sum, trial;

  assign start_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
  assign start_div    = (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU);
  assign mag_a        = (start_signed && a[XLEN-1]) ? -a : a;
  assign mag_b        = (start_signed && b[XLEN-1]) ? -b : b;

  assign busy = (state == BUSY);
  assign done = busy && (count == 5'd31);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    trial    = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    acc_next = acc;
    if (is_div)
      acc_next = trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                             : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      acc_next = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
  end

  // Only sampled by the HI/LO registers when done is high.
  always_comb begin
    hi_out = acc_next[2*XLEN-1:XLEN];
    lo_out = acc_next[XLEN-1:0];
    if (is_div) begin
      if (div_zero) begin
        hi_out = a_raw;
        lo_out = '1;
      end else begin
        hi_out = neg_hi ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        lo_out = neg_lo ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      end
    end else if (neg_lo) begin
      {hi_out, lo_out} = -acc_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are reset too; a reset mid-operation must
    // leave nothing that could later be mistaken for a result.
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= BUSY;
          count    <= '0;
          is_div   <= start_div;
          a_raw    <= a;
          div_zero <= start_div && (b == '0);
          neg_lo   <= start_signed && (a[XLEN-1] ^ b[XLEN-1]);
          neg_hi   <= start_signed && a[XLEN-1];
          acc      <= {{XLEN{1'b0}}, start_div ? mag_a : mag_b};
          opnd     <= start_div ? mag_b : mag_a;
        end
        BUSY: begin
          acc   <= acc_next;
          count <= count + 5'd1;
          if (count == 5'd31) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mips_alu.sv
// Execute-stage ALU: combinational datapath, HI/LO registers and the stall
// that holds HI/LO users while the iterative multiply/divide is running.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [5:0]      fncode,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic            busy, done, start;
  logic [XLEN-1:0] hi_out, lo_out;

  assign stall = en && busy && needs_hilo(fncode);
  assign start = en && !busy && is_muldiv_op(fncode);

  mips_muldiv u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .fncode (fncode),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always_comb begin
    result = '0;
    case (fncode)
      FUNCT_ADDU: result = a + b;
      FUNCT_SUBU: result = a - b;
      FUNCT_AND:  result = a & b;
      FUNCT_OR:   result = a | b;
      FUNCT_XOR:  result = a ^ b;
      FUNCT_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      FUNCT_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      FUNCT_SLL:  result = b << shamt;
      FUNCT_SRL:  result = b >> shamt;
      FUNCT_SRA:  result = $signed(b) >>> shamt;
      FUNCT_SLLV: result = b << a[4:0];
      FUNCT_SRLV: result = b >> a[4:0];
      FUNCT_SRAV: result = $signed(b) >>> a[4:0];
      FUNCT_MFHI: result = hi;
      FUNCT_MFLO: result = lo;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

  // Completion and MTHI/MTLO never coincide: moves stall while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (done) begin
      hi <= hi_out;
      lo <= lo_out;
    end else if (en && !stall) begin
      if (fncode == FUNCT_MTHI) hi <= a;
      if (fncode == FUNCT_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed combinational vectors plus a
// scoreboard of expected {HI,LO} pairs for multiply/divide operations.
module tb_mips_alu;
  import mips_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, en;
  logic [5:0]  fncode;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic [31:0] result, hi, lo;
  logic        zero, stall;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [5:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  sh;
    logic [31:0] exp;
  } comb_vec_t;

  mips_alu dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .fncode (fncode),
    .a      (a),
    .b      (b),
    .shamt  (shamt),
    .result (result),
    .zero   (zero),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [5:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] sh = 5'd0);
    en = e; fncode = f; a = x; b = y; shamt = sh;
  endtask

  // Counts cycles with stall high, bounded; the caller checks the count.
  task automatic wait_stall(output int n);
    n = 0;
    sample();
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
      sample();
    end
  endtask

  // Reference {HI,LO} computed with the simulator's own arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x,
                                        input logic [31:0] y);
    logic [63:0] p;
    case (f)
      FUNCT_MULT:  p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
      FUNCT_MULTU: p = {32'b0, x} * {32'b0, y};
      FUNCT_DIV:   p = (y == 0) ? {x, 32'hFFFF_FFFF}
                                : {32'($signed(x) % $signed(y)), 32'($signed(x) / $signed(y))};
      FUNCT_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default:     p = '0;
    endcase
    return p;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, FUNCT_ADDU, 32'h0, 32'h0);
    tick(); tick();
    sample();
    checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_comb();
    comb_vec_t v [13];
    v = '{'{FUNCT_ADDU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0},
          '{FUNCT_SLT,  32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1},
          '{FUNCT_SLTU, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0},
          '{FUNCT_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000},
          '{FUNCT_SUBU, 32'h5,         32'h7,         5'd0,  32'hFFFF_FFFE},
          '{FUNCT_AND,  32'hF0F0,      32'hFF00,      5'd0,  32'hF000},
          '{FUNCT_OR,   32'hF0F0,      32'hFF00,      5'd0,  32'hFFF0},
          '{FUNCT_XOR,  32'hF0F0,      32'hFF00,      5'd0,  32'h0FF0},
          '{FUNCT_SLL,  32'h0,         32'h1,         5'd31, 32'h8000_0000},
          '{FUNCT_SRL,  32'h0,         32'h8000_0000, 5'd31, 32'h1},
          '{FUNCT_SLLV, 32'h4,         32'h3,         5'd0,  32'h30},
          '{FUNCT_SRLV, 32'h24,        32'hF0,        5'd9,  32'hF},
          '{FUNCT_SRAV, 32'h1,         32'h8000_0000, 5'd0,  32'hC000_0000}};
    for (int i = 0; i < 13; i++) begin
      tick();
      drive(i[0], v[i].f, v[i].x, v[i].y, v[i].sh);
      sample();
      checks++; if (result !== v[i].exp) begin failures++; $display("FAIL comb_result[%0d] fn=%b got=%h exp=%h", i, v[i].f, result, v[i].exp); end
      checks++; if (zero !== (v[i].exp == 32'h0)) begin failures++; $display("FAIL comb_zero[%0d] got=%b exp=%b", i, zero, v[i].exp == 32'h0); end
    end
  endtask

  task automatic test_hilo_move();
    tick(); drive(1'b1, FUNCT_MTHI, 32'h1234, 32'h0);
    sample();
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL mthi_result got=%h exp=0", result); end
    tick(); drive(1'b1, FUNCT_MTLO, 32'h5678, 32'h0);
    tick(); drive(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    sample();
    checks++; if (result !== 32'h1234) begin failures++; $display("FAIL mfhi_result got=%h exp=1234", result); end
    tick(); drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    sample();
    checks++; if (result !== 32'h5678) begin failures++; $display("FAIL mflo_result got=%h exp=5678", result); end
  endtask

  task automatic test_nop();
    tick(); drive(1'b1, FUNCT_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    sample();
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL nop_result got=%h exp=0", result); end
    checks++; if (zero !== 1'b1) begin failures++; $display("FAIL nop_zero got=%b exp=1", zero); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL nop_stall got=%b exp=0", stall); end
    tick(); drive(1'b0, FUNCT_ADDU, 32'h0, 32'h0);
    sample();
    checks++; if ({hi, lo} !== {32'h1234, 32'h5678}) begin failures++; $display("FAIL nop_hilo got=%h_%h exp=1234_5678", hi, lo); end
  endtask

  // Issue one mul/div, follow immediately with MFLO and wait for it.
  task automatic run_muldiv(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    int n;
    logic [63:0] e;
    tick(); drive(1'b1, f, x, y);
    exp_q.push_back(model(f, x, y));
    sample();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL md_issue_stall fn=%b got=%b exp=0", f, stall); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL md_issue_result fn=%b got=%h exp=0", f, result); end
    tick(); drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    wait_stall(n);
    e = exp_q.pop_front();
    checks++; if (n !== 32) begin failures++; $display("FAIL md_latency fn=%b got=%0d exp=32", f, n); end
    checks++; if (result !== e[31:0]) begin failures++; $display("FAIL md_mflo fn=%b a=%h b=%h got=%h exp=%h", f, x, y, result, e[31:0]); end
    checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL md_hi fn=%b a=%h b=%h got=%h exp=%h", f, x, y, hi, e[63:32]); end
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
  endtask

  task automatic test_muldiv();
    logic [5:0]  ops [4];
    logic [5:0]  f;
    logic [31:0] x, y;
    ops = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    run_muldiv(FUNCT_MULT,  32'hFFFF_FFFD, 32'd7);
    run_muldiv(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_muldiv(FUNCT_DIV,   32'hFFFF_FFF9, 32'd2);
    run_muldiv(FUNCT_DIVU,  32'd7,         32'd0);
    run_muldiv(FUNCT_DIV,   32'd100,       32'hFFFF_FFF9);
    run_muldiv(FUNCT_DIV,   32'hFFFF_FFFB, 32'd0);
    run_muldiv(FUNCT_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF);
    run_muldiv(FUNCT_DIVU,  32'hFFFF_FFFF, 32'h10);
    for (int i = 0; i < 6; i++) begin
      f = ops[$urandom_range(0, 3)];
      x = $urandom;
      y = (i == 2) ? 32'h0 : $urandom;
      if (f == FUNCT_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'h1;
      run_muldiv(f, x, y);
    end
  endtask

  // One idle cycle between MULT and MFLO: the MFLO stalls for 31 cycles.
  task automatic test_stall_window();
    int n;
    logic [63:0] e;
    tick(); drive(1'b1, FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);
    exp_q.push_back(model(FUNCT_MULT, 32'hFFFF_FFFD, 32'd7));
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
    tick(); drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    wait_stall(n);
    e = exp_q.pop_front();
    checks++; if (n !== 31) begin failures++; $display("FAIL window_stall_cycles got=%0d exp=31", n); end
    checks++; if (result !== e[31:0]) begin failures++; $display("FAIL window_mflo got=%h exp=%h", result, e[31:0]); end
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
  endtask

  task automatic test_busy_bypass();
    int n;
    logic [63:0] e;
    tick(); drive(1'b1, FUNCT_MULTU, 32'h0001_0001, 32'h0003_0000);
    exp_q.push_back(model(FUNCT_MULTU, 32'h0001_0001, 32'h0003_0000));
    tick(); drive(1'b1, FUNCT_ADDU, 32'd5, 32'd6);
    sample();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL bypass_addu_stall got=%b exp=0", stall); end
    checks++; if (result !== 32'd11) begin failures++; $display("FAIL bypass_addu_result got=%h exp=b", result); end
    tick(); drive(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    wait_stall(n);
    e = exp_q.pop_front();
    checks++; if (n !== 31) begin failures++; $display("FAIL bypass_mfhi_cycles got=%0d exp=31", n); end
    checks++; if (result !== e[63:32]) begin failures++; $display("FAIL bypass_mfhi got=%h exp=%h", result, e[63:32]); end
    checks++; if (lo !== e[31:0]) begin failures++; $display("FAIL bypass_lo got=%h exp=%h", lo, e[31:0]); end
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int n;
    logic [63:0] e;
    tick(); drive(1'b1, FUNCT_MULT, 32'hFFFF_FF00, 32'h0000_0300);
    exp_q.push_back(model(FUNCT_MULT, 32'hFFFF_FF00, 32'h0000_0300));
    tick(); drive(1'b1, FUNCT_DIV, 32'd1000, 32'hFFFF_FFFD);
    exp_q.push_back(model(FUNCT_DIV, 32'd1000, 32'hFFFF_FFFD));
    wait_stall(n);
    e = exp_q.pop_front();
    checks++; if (n !== 32) begin failures++; $display("FAIL b2b_first_stall got=%0d exp=32", n); end
    checks++; if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_first_hilo got=%h_%h exp=%h", hi, lo, e); end
    tick(); drive(1'b1, FUNCT_MFLO, 32'h0, 32'h0);
    wait_stall(n);
    e = exp_q.pop_front();
    checks++; if (n !== 32) begin failures++; $display("FAIL b2b_second_stall got=%0d exp=32", n); end
    checks++; if (result !== e[31:0]) begin failures++; $display("FAIL b2b_second_lo got=%h exp=%h", result, e[31:0]); end
    checks++; if (hi !== e[63:32]) begin failures++; $display("FAIL b2b_second_hi got=%h exp=%h", hi, e[63:32]); end
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
  endtask

  task automatic test_reset_midop();
    tick(); drive(1'b1, FUNCT_DIVU, 32'd100, 32'd3);
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, FUNCT_MFHI, 32'h0, 32'h0);
    sample();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_mid_stall got=%b exp=0", stall); end
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", hi, lo); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL rst_mid_mfhi got=%h exp=0", result); end
    tick(); drive(1'b0, FUNCT_NOP, 32'h0, 32'h0);
    repeat (40) tick();
    sample();
    checks++; if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL rst_mid_late_write got=%h_%h exp=0_0", hi, lo); end
  endtask

  initial begin
    drive(1'b0, FUNCT_ADDU, 32'h0, 32'h0);
    test_reset();
    test_comb();
    test_hilo_move();
    test_nop();
    test_muldiv();
    test_stall_window();
    test_busy_bypass();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
